// File: rtl/uart_image_tx_if.sv
// rtl/uart_image_tx_if.sv - processing-unit / UART handshake bundle for uart_image_tx
interface uart_image_tx_if;
  logic       transmite;
  logic [7:0] dados;
  logic       tx_pronto;
  logic       saida_serial;
  logic       ocupado;
  logic       fim_transmissao;

  modport master (
    output transmite, dados,
    input  tx_pronto, saida_serial, ocupado, fim_transmissao
  );

  modport slave (
    input  transmite, dados,
    output tx_pronto, saida_serial, ocupado, fim_transmissao
  );
endinterface

// File: rtl/uart_image_tx.sv
// rtl/uart_image_tx.sv - streams a packed 4-bit image out as UART 8N1 bytes
// One byte per SETTLE..ACK pass; tx_pronto in ACK advances the upstream read pointer.
module uart_image_tx #(
  parameter int HEIGHT       = 2,
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  uart_image_tx_if.slave bus
);

  localparam int TOTAL = (WIDTH / 2) * HEIGHT;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_BYTE = CW'(TOTAL - 1);
  localparam logic [BW-1:0] LAST_TICK = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, LOAD, START, DATA, STOP, ACK, DONE
  } state_t;

  state_t        state, state_next;
  logic [BW-1:0] bit_cnt, bit_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [CW-1:0] byte_cnt, byte_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          serial_q, serial_next;
  logic          bit_done;

  assign bit_done = (bit_cnt == LAST_TICK);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bit_cnt_next  = '0;
    bit_idx_next  = bit_idx;
    byte_cnt_next = byte_cnt;
    shift_next    = shift_reg;
    case (state)
      IDLE: begin
        bit_idx_next = '0;
        if (bus.transmite) begin
          byte_cnt_next = '0;
          state_next    = SETTLE;
        end
      end
      SETTLE: state_next = LOAD;
      LOAD: begin
        shift_next = bus.dados;
        state_next = START;
      end
      START: begin
        bit_cnt_next = bit_done ? '0 : bit_cnt + 1'b1;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        bit_cnt_next = bit_done ? '0 : bit_cnt + 1'b1;
        // The line always shows shift_reg[0]; shifting on each bit boundary walks LSB first.
        if (bit_done) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        bit_cnt_next = bit_done ? '0 : bit_cnt + 1'b1;
        if (bit_done) state_next = ACK;
      end
      ACK: begin
        if (byte_cnt == LAST_BYTE) begin
          state_next = DONE;
        end else begin
          byte_cnt_next = byte_cnt + 1'b1;
          state_next    = SETTLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the registered output lines up with the state.
  always_comb begin
    serial_next = 1'b1;
    if (state_next == START) begin
      serial_next = 1'b0;
    end else if (state_next == DATA) begin
      serial_next = shift_next[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
      serial_q  <= 1'b1;
    end else begin
      bit_cnt   <= bit_cnt_next;
      bit_idx   <= bit_idx_next;
      byte_cnt  <= byte_cnt_next;
      shift_reg <= shift_next;
      serial_q  <= serial_next;
    end
  end

  assign bus.saida_serial    = serial_q;
  assign bus.tx_pronto       = (state == ACK);
  assign bus.ocupado         = (state != IDLE);
  assign bus.fim_transmissao = (state == DONE);

endmodule

// File: tb/tb_uart_image_tx.sv
// tb/tb_uart_image_tx.sv - directed self-checking bench for uart_image_tx
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_image_tx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_image_tx_if u_if ();

  uart_image_tx #(.HEIGHT(2), .WIDTH(4), .CLKS_PER_BIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pronto_cnt = 0;
  int fim_cnt = 0;
  int pronto_back2back = 0;
  logic prev_pronto = 1'b0;

  logic [7:0] rom [4] = '{8'h5A, 8'hED, 8'h0F, 8'hF0};
  logic [1:0] ptr = 2'd0;
  logic       pu_clr = 1'b1;
  logic       pu_en = 1'b0;
  logic       tog_en = 1'b0;
  logic [7:0] tog_val = 8'h00;
  logic [7:0] dados_drv = 8'h00;

  assign u_if.dados = pu_en ? rom[ptr] : (tog_en ? tog_val : dados_drv);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (u_if.tx_pronto === 1'b1) pronto_cnt <= pronto_cnt + 1;
    if (u_if.fim_transmissao === 1'b1) fim_cnt <= fim_cnt + 1;
    if (prev_pronto && u_if.tx_pronto === 1'b1) pronto_back2back <= pronto_back2back + 1;
    prev_pronto <= (u_if.tx_pronto === 1'b1);
    if (pu_clr) ptr <= 2'd0;
    else if (u_if.tx_pronto === 1'b1) ptr <= ptr + 2'd1;
  end

  always @(negedge clock) begin
    if (tog_en) tog_val <= tog_val + 8'h37;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on a falling edge; returns on the falling edge inside the stop bit.
  task automatic rx_byte(output logic [7:0] b, output logic ok, output logic stop);
    int w = 0;
    b = 8'h00;
    ok = 1'b1;
    stop = 1'b0;
    while (u_if.saida_serial !== 1'b0 && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (w >= 200) begin
      ok = 1'b0;
      return;
    end
    repeat (6) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      b[i] = u_if.saida_serial;
      if (i < 7) repeat (4) @(negedge clock);
    end
    repeat (4) @(negedge clock);
    stop = u_if.saida_serial;
  endtask

  task automatic wait_fim(output int tf, output logic ok);
    int w = 0;
    while (u_if.fim_transmissao !== 1'b1 && w < 400) begin
      @(negedge clock);
      w++;
    end
    ok = (w < 400);
    tf = cyc;
  endtask

  // Pulses transmite for one sampling edge; returns on the falling edge after it with t0 = cycle of that edge.
  task automatic kick(output int t0);
    u_if.transmite = 1'b1;
    @(negedge clock);
    u_if.transmite = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    logic [9:0]  frame_bits;
    logic [7:0]  rx;
    logic [7:0]  exp_bytes [4];
    logic        ok, stop;
    int          t0, tf, p0, f0;

    exp_bytes = '{8'h5A, 8'hED, 8'h0F, 8'hF0};
    u_if.transmite = 1'b0;

    // Reset held three cycles
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_serial", u_if.saida_serial, 1);
    chk("rst_ocupado", u_if.ocupado, 0);
    chk("rst_tx_pronto", u_if.tx_pronto, 0);
    chk("rst_fim", u_if.fim_transmissao, 0);
    reset = 1'b0;
    pu_clr = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_ocupado", u_if.ocupado, 0);

    // Constant A5: bit-exact line waveform of the first byte
    dados_drv = 8'hA5;
    p0 = pronto_cnt;
    f0 = fim_cnt;
    kick(t0);
    chk("settle_ocupado", u_if.ocupado, 1);
    chk("settle_serial", u_if.saida_serial, 1);
    @(negedge clock);
    chk("load_serial", u_if.saida_serial, 1);
    @(negedge clock);
    frame_bits = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("a5_bit%0d_t%0d", b, k), u_if.saida_serial, frame_bits[b]);
        chk("a5_no_pronto", u_if.tx_pronto, 0);
        @(negedge clock);
      end
    end
    chk("a5_ack_pronto", u_if.tx_pronto, 1);
    chk("a5_ack_serial", u_if.saida_serial, 1);
    @(negedge clock);
    chk("a5_pronto_single", u_if.tx_pronto, 0);
    chk("a5_settle_serial", u_if.saida_serial, 1);
    wait_fim(tf, ok);
    chk("a5_fim_seen", ok, 1);
    chk("a5_fim_latency", tf - t0 + 1, 173);
    @(negedge clock);
    chk("a5_pronto_total", pronto_cnt - p0, 4);
    chk("a5_fim_total", fim_cnt - f0, 1);
    chk("a5_back_idle", u_if.ocupado, 0);

    // Processing-unit model, with transmite re-asserted while busy
    pu_clr = 1'b1;
    @(negedge clock);
    pu_clr = 1'b0;
    pu_en = 1'b1;
    p0 = pronto_cnt;
    f0 = fim_cnt;
    kick(t0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) u_if.transmite = 1'b1;
      if (i == 3) u_if.transmite = 1'b0;
      rx_byte(rx, ok, stop);
      chk($sformatf("pu_rx_ok%0d", i), ok, 1);
      chk($sformatf("pu_byte%0d", i), rx, exp_bytes[i]);
      chk($sformatf("pu_stop%0d", i), stop, 1);
    end
    wait_fim(tf, ok);
    chk("pu_fim_seen", ok, 1);
    chk("pu_fim_latency", tf - t0 + 1, 173);
    repeat (3) @(negedge clock);
    chk("pu_pronto_total", pronto_cnt - p0, 4);
    chk("pu_fim_total", fim_cnt - f0, 1);
    chk("pu_no_restart", u_if.ocupado, 0);

    // Reset during DATA bit 3 of the third byte (0F)
    pu_clr = 1'b1;
    @(negedge clock);
    pu_clr = 1'b0;
    p0 = pronto_cnt;
    f0 = fim_cnt;
    kick(t0);
    repeat (105) @(negedge clock);
    chk("abort_pre_bit3", u_if.saida_serial, 1);
    chk("abort_pre_pronto", pronto_cnt - p0, 2);
    reset = 1'b1;
    u_if.transmite = 1'b1;
    @(negedge clock);
    chk("abort_serial", u_if.saida_serial, 1);
    chk("abort_ocupado", u_if.ocupado, 0);
    chk("abort_fim", u_if.fim_transmissao, 0);
    chk("abort_pronto", u_if.tx_pronto, 0);
    reset = 1'b0;
    u_if.transmite = 1'b0;
    repeat (60) @(negedge clock);
    chk("abort_no_more_pronto", pronto_cnt - p0, 2);
    chk("abort_no_fim", fim_cnt - f0, 0);
    chk("abort_idle", u_if.ocupado, 0);

    // Restart after abort runs a full four-byte image
    pu_clr = 1'b1;
    @(negedge clock);
    pu_clr = 1'b0;
    p0 = pronto_cnt;
    kick(t0);
    for (int i = 0; i < 4; i++) begin
      rx_byte(rx, ok, stop);
      chk($sformatf("re_byte%0d", i), rx, exp_bytes[i]);
    end
    wait_fim(tf, ok);
    chk("re_fim_seen", ok, 1);
    chk("re_fim_latency", tf - t0 + 1, 173);
    @(negedge clock);
    chk("re_pronto_total", pronto_cnt - p0, 4);

    // dados churning everywhere except the LOAD exit edge
    pu_en = 1'b0;
    tog_en = 1'b1;
    @(negedge clock);
    kick(t0);
    @(negedge clock);
    tog_en = 1'b0;
    dados_drv = 8'h3C;
    @(negedge clock);
    tog_en = 1'b1;
    rx_byte(rx, ok, stop);
    chk("tog_rx_ok", ok, 1);
    chk("tog_byte", rx, 8'h3C);
    wait_fim(tf, ok);
    chk("tog_fim_seen", ok, 1);
    tog_en = 1'b0;
    @(negedge clock);

    chk("pronto_never_back2back", pronto_back2back, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
